// File: rtl/axis_read_address.sv
// axis_read_address
//   AXI read-address channel generator for one read stream job. A job
//   (start address, length in stream words) is split into INCR bursts of at
//   most BURST_NB beats that never cross a 4KB boundary. The bursts are then
//   issued one at a time on the AR channel.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cfg_address/length  job start byte address and length in stream words
//   cfg_valid/ready     job handshake (ready only while idle)
//   axi_ar*             AXI read-address channel (INCR, full-width beats)
//   busy                high while a job is in progress
module axis_read_address #(
    parameter int unsigned CFG_AWIDTH     = 32,
    parameter int unsigned CFG_DWIDTH     = 32,
    parameter int unsigned WIDTH_RATIO    = 2,
    parameter int unsigned BURST_NB       = 16,
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CFG_AWIDTH-1:0]     cfg_address,
    input  logic [CFG_DWIDTH-1:0]     cfg_length,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    output logic [AXI_ADDR_WIDTH-1:0] axi_araddr,
    output logic [3:0]                axi_arlen,
    output logic [2:0]                axi_arsize,
    output logic [1:0]                axi_arburst,
    output logic                      axi_arvalid,
    input  logic                      axi_arready,
    output logic                      busy
);

    localparam int unsigned BYTES      = AXI_DATA_WIDTH / 8;
    localparam int unsigned SIZE_LOG2  = $clog2(BYTES);
    localparam int unsigned RATIO_LOG2 = $clog2(WIDTH_RATIO);
    localparam int unsigned BW         = CFG_DWIDTH + 1;
    localparam int unsigned LW         = 5;
    localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK = ~AXI_ADDR_WIDTH'(BYTES - 1);

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        SETUP = 4'b0010,
        ISSUE = 4'b0100,
        DONE  = 4'b1000
    } state_t;

    state_t                    state;
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [BW-1:0]             beats;
    logic [LW-1:0]             burst;

    logic [BW-1:0]             beats_in_c;
    logic [AXI_ADDR_WIDTH-1:0] addr_in_c;
    logic [12:0]               bnd_c;
    logic [BW-1:0]             burst_lim_c;

    assign axi_arsize  = 3'(SIZE_LOG2);
    assign axi_arburst = 2'b01;

    // Job decode and next-burst size: min(remaining beats, BURST_NB, beats to 4KB edge)
    always_comb begin
        beats_in_c  = (BW'(cfg_length) + BW'(WIDTH_RATIO - 1)) >> RATIO_LOG2;
        addr_in_c   = AXI_ADDR_WIDTH'(cfg_address) & ALIGN_MASK;
        bnd_c       = (13'd4096 - {1'b0, addr[11:0]}) >> SIZE_LOG2;
        burst_lim_c = beats;
        if (burst_lim_c > BW'(BURST_NB)) begin
            burst_lim_c = BW'(BURST_NB);
        end
        if (burst_lim_c > BW'(bnd_c)) begin
            burst_lim_c = BW'(bnd_c);
        end
    end

    // Control FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            addr        <= '0;
            beats       <= '0;
            burst       <= '0;
            axi_araddr  <= '0;
            axi_arlen   <= '0;
            axi_arvalid <= 1'b0;
            busy        <= 1'b0;
            cfg_ready   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        addr      <= addr_in_c;
                        beats     <= beats_in_c;
                        cfg_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    if (beats == '0) begin
                        state <= DONE;
                    end else begin
                        burst       <= LW'(burst_lim_c);
                        axi_araddr  <= addr;
                        axi_arlen   <= 4'(burst_lim_c - BW'(1));
                        axi_arvalid <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    // arvalid is always high here, so arready alone completes the handshake
                    if (axi_arready) begin
                        axi_arvalid <= 1'b0;
                        addr        <= addr + (AXI_ADDR_WIDTH'(burst) << SIZE_LOG2);
                        beats       <= beats - BW'(burst);
                        state       <= (beats == BW'(burst)) ? DONE : SETUP;
                    end
                end
                DONE: begin
                    busy      <= 1'b0;
                    cfg_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    axi_arvalid <= 1'b0;
                    busy        <= 1'b0;
                    cfg_ready   <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_read_address.sv
// tb_axis_read_address
//   Directed bench for axis_read_address with 64-bit AXI data, two stream
//   words per beat and 16-beat maximum bursts. Inputs change on the falling
//   edge; outputs are sampled on the falling edge.
module tb_axis_read_address;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cfg_address;
    logic [31:0] cfg_length;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] axi_araddr;
    logic [3:0]  axi_arlen;
    logic [2:0]  axi_arsize;
    logic [1:0]  axi_arburst;
    logic        axi_arvalid;
    logic        axi_arready;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axis_read_address #(
        .CFG_AWIDTH(32), .CFG_DWIDTH(32), .WIDTH_RATIO(2), .BURST_NB(16),
        .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_address(cfg_address), .cfg_length(cfg_length),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
        .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Present a job for one cycle; returns on the falling edge after acceptance
    task automatic start_job(input logic [31:0] a, input logic [31:0] l);
        cfg_address = a;
        cfg_length  = l;
        cfg_valid   = 1'b1;
        tick();
        cfg_valid   = 1'b0;
    endtask

    // Wait (bounded) for arvalid, then compare the presented burst
    task automatic expect_ar(input string tag, input logic [31:0] a, input logic [3:0] len);
        int n = 0;
        while (!axi_arvalid && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_arvalid"}, 64'(axi_arvalid), 64'd1);
        check({tag, "_araddr"}, 64'(axi_araddr), 64'(a));
        check({tag, "_arlen"}, 64'(axi_arlen), 64'(len));
    endtask

    // Wait (bounded) for the job to finish, failing if an extra AR appears
    task automatic expect_idle(input string tag);
        int n = 0;
        int extra = 0;
        while (!(cfg_ready && !busy) && n < 40) begin
            if (axi_arvalid) extra++;
            tick();
            n++;
        end
        check({tag, "_idle"}, 64'(cfg_ready && !busy), 64'd1);
        check({tag, "_no_extra_ar"}, 64'(extra), 64'd0);
    endtask

    initial begin
        rst         = 1'b1;
        cfg_address = '0;
        cfg_length  = '0;
        cfg_valid   = 1'b0;
        axi_arready = 1'b0;
        tick(); tick(); tick();
        rst = 1'b0;

        // Reset state and constant AR attributes
        check("rst_cfg_ready", 64'(cfg_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_arvalid", 64'(axi_arvalid), 64'd0);
        check("rst_araddr", 64'(axi_araddr), 64'd0);
        check("rst_arlen", 64'(axi_arlen), 64'd0);
        check("arsize", 64'(axi_arsize), 64'd3);
        check("arburst", 64'(axi_arburst), 64'd1);

        // 1: 0x1000, 64 words -> two 16-beat bursts, exact cycle timing
        axi_arready = 1'b1;
        start_job(32'h1000, 32'd64);
        check("t1_busy_acc", 64'(busy), 64'd1);
        check("t1_ready_acc", 64'(cfg_ready), 64'd0);
        check("t1_arvalid_setup", 64'(axi_arvalid), 64'd0);
        tick();
        check("t1_b0_arvalid", 64'(axi_arvalid), 64'd1);
        check("t1_b0_araddr", 64'(axi_araddr), 64'h1000);
        check("t1_b0_arlen", 64'(axi_arlen), 64'd15);
        tick();
        check("t1_gap_arvalid", 64'(axi_arvalid), 64'd0);
        tick();
        check("t1_b1_arvalid", 64'(axi_arvalid), 64'd1);
        check("t1_b1_araddr", 64'(axi_araddr), 64'h1080);
        check("t1_b1_arlen", 64'(axi_arlen), 64'd15);
        tick();
        check("t1_done_arvalid", 64'(axi_arvalid), 64'd0);
        check("t1_done_busy", 64'(busy), 64'd1);
        tick();
        check("t1_end_busy", 64'(busy), 64'd0);
        check("t1_end_ready", 64'(cfg_ready), 64'd1);

        // 2: 4KB crossing splits 4 beats into 2+2
        start_job(32'h1FF0, 32'd8);
        expect_ar("t2_b0", 32'h1FF0, 4'd1);
        tick();
        expect_ar("t2_b1", 32'h2000, 4'd1);
        tick();
        expect_idle("t2");

        // 3: odd length rounds up to 3 beats, single burst
        start_job(32'h0, 32'd5);
        expect_ar("t3_b0", 32'h0, 4'd2);
        tick();
        check("t3_after_arvalid", 64'(axi_arvalid), 64'd0);
        tick();
        check("t3_after_busy", 64'(busy), 64'd0);

        // 4: arready held low for 10 cycles, AR must stay stable
        axi_arready = 1'b0;
        start_job(32'h3000, 32'd4);
        expect_ar("t4_b0", 32'h3000, 4'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t4_hold_arvalid", 64'(axi_arvalid), 64'd1);
            check("t4_hold_araddr", 64'(axi_araddr), 64'h3000);
            check("t4_hold_arlen", 64'(axi_arlen), 64'd1);
        end
        axi_arready = 1'b1;
        tick();
        check("t4_release_arvalid", 64'(axi_arvalid), 64'd0);
        expect_idle("t4");

        // 5: zero length, no AR, cfg_ready back 3 cycles after acceptance
        start_job(32'h5000, 32'd0);
        check("t5_c1_ready", 64'(cfg_ready), 64'd0);
        check("t5_c1_arvalid", 64'(axi_arvalid), 64'd0);
        tick();
        check("t5_c2_ready", 64'(cfg_ready), 64'd0);
        check("t5_c2_arvalid", 64'(axi_arvalid), 64'd0);
        tick();
        check("t5_c3_ready", 64'(cfg_ready), 64'd1);
        check("t5_c3_arvalid", 64'(axi_arvalid), 64'd0);
        check("t5_c3_busy", 64'(busy), 64'd0);

        // 6: reset in the middle of ISSUE aborts, then a fresh 1-beat job
        axi_arready = 1'b0;
        start_job(32'h1000, 32'd64);
        expect_ar("t6_pre", 32'h1000, 4'd15);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_arvalid", 64'(axi_arvalid), 64'd0);
        check("t6_rst_ready", 64'(cfg_ready), 64'd1);
        check("t6_rst_busy", 64'(busy), 64'd0);
        axi_arready = 1'b1;
        start_job(32'h4000, 32'd2);
        expect_ar("t6_b0", 32'h4000, 4'd0);
        tick();
        expect_idle("t6");

        // Misaligned start address has its low 3 bits cleared
        start_job(32'h1003, 32'd1);
        expect_ar("t7_b0", 32'h1000, 4'd0);
        tick();
        expect_idle("t7");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute watchdog: report and stop if the sequence stalls
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
